uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/uart_tx_param.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the parameterised UART transmitter:
//   - uart_state_e : transmitter FSM states
//   - PAR_*        : parity-mode selector values for the PARITY parameter
//   - parity_bit() : parity bit for a data word under a given parity mode
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Caller zero-extends the word, so unused upper bits never disturb the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic p;
        case (mode)
            PAR_NONE: p = 1'b0;
            PAR_ODD:  p = ~^data;   // total ones (data + parity) odd
            PAR_EVEN: p = ^data;    // total ones (data + parity) even
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Bit-time counter for the UART transmitter. Counts CLKS_PER_BIT cycles per
// serial bit and pulses bit_tick_o on the last cycle of each bit; the counter
// reloads to zero on that same edge, so consecutive bits abut exactly.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - asynchronous active-high reset
//   start_i    - hold the counter at zero (asserted while the line is idle so
//                the first bit of a frame starts from a clean count)
//   bit_tick_o - high during the final cycle of the current bit
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic bit_tick_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (start_i || bit_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parameterised UART transmitter with a one-entry holding register in front
// of the shift register, allowing back-to-back frames with no idle gap.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Ports:
//   tx_clk   - clock, rising edge
//   reset    - asynchronous active-high reset; aborts any frame in flight
//   tx_valid - tx_data holds a word to send
//   tx_data  - payload word
//   tx_ready - holding register empty (registered, independent of tx_valid)
//   tx_done  - one-cycle pulse in the cycle after the last stop-bit cycle
//   tx_busy  - high whenever a frame bit is on the line
//   tx       - serial line, idles high
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 tx_clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 tx_busy,
    output logic                 tx
);

    uart_state_e          state_q, state_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 done_q;

    logic bit_tick;
    logic accept;
    logic last_data;
    logic last_stop;
    logic frame_end;
    logic load;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i      (tx_clk),
        .rst_i      (reset),
        .start_i    (state_q == S_IDLE),
        .bit_tick_o (bit_tick)
    );

    assign accept    = tx_valid && !hold_full_q;
    assign last_data = (bit_cnt_q == 4'(DATA_BITS - 1));
    assign last_stop = (bit_cnt_q == 4'(STOP_BITS - 1));
    assign frame_end = (state_q == S_STOP) && bit_tick && last_stop;
    // Transfer holding -> shift whenever the FSM is about to enter START.
    assign load      = hold_full_q && ((state_q == S_IDLE) || frame_end);

    assign tx_ready  = !hold_full_q;
    assign tx_done   = done_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hold_full_q) state_d = S_START;
            end
            S_START: begin
                if (bit_tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_tick && last_data) begin
                    state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (frame_end) state_d = hold_full_q ? S_START : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        tx      = 1'b1;
        tx_busy = (state_q != S_IDLE);
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_q[0];
            S_PARITY: tx = parity_q;
            default:  tx = 1'b1;
        endcase
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;

        if (load) begin
            hold_full_d = 1'b0;
            shift_d     = hold_data_q;
            parity_d    = parity_bit(9'(hold_data_q), PARITY);
        end
        // Accept after load so a same-cycle accept leaves the new word held.
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end

        if (bit_tick) begin
            case (state_q)
                S_DATA: begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = last_data ? 4'd0 : bit_cnt_q + 4'd1;
                end
                S_STOP: begin
                    bit_cnt_d = last_stop ? 4'd0 : bit_cnt_q + 4'd1;
                end
                default: bit_cnt_d = 4'd0;
            endcase
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= 4'd0;
            done_q      <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            done_q      <= frame_end;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
`timescale 1ns/1ps
module tb_uart_tx_param;

    localparam int NI = 4;

    // Instance table: 0 defaults, 1 7-bit even, 2 7-bit odd, 3 two stop bits.
    function automatic int p_db(input int i);
        case (i)
            1, 2:    return 7;
            default: return 8;
        endcase
    endfunction
    function automatic int p_cpb(input int i);
        return (i == 0) ? 16 : 4;
    endfunction
    function automatic int p_par(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int p_sb(input int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic int p_nb(input int i);
        return 1 + p_db(i) + ((p_par(i) != 0) ? 1 : 0) + p_sb(i);
    endfunction

    // Reference frame: bit k of the result is the k-th bit on the line.
    function automatic logic [15:0] exp_frame(input int i, input logic [8:0] d);
        logic [15:0] f;
        int k;
        int ones;
        f = '0;
        k = 1;
        ones = 0;
        for (int b = 0; b < p_db(i); b++) begin
            f[k] = d[b];
            if (d[b]) ones++;
            k++;
        end
        if (p_par(i) == 1) begin
            f[k] = (ones % 2 == 0);
            k++;
        end else if (p_par(i) == 2) begin
            f[k] = (ones % 2 == 1);
            k++;
        end
        for (int s = 0; s < p_sb(i); s++) begin
            f[k] = 1'b1;
            k++;
        end
        return f;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid [NI];
    logic [8:0] data  [NI];
    logic       ready [NI];
    logic       done  [NI];
    logic       busy  [NI];
    logic       line  [NI];

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0]  exp_q [NI][$];
    logic [15:0] got_q [NI][$];
    int          st_q  [NI][$];
    int          done_cnt [NI];
    int          cyc;

    logic        mact [NI];
    int          mb   [NI];
    int          mc   [NI];
    logic [15:0] mfr  [NI];

    initial forever #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int DB = p_db(gi);
        uart_tx_param #(
            .DATA_BITS   (DB),
            .CLKS_PER_BIT(p_cpb(gi)),
            .PARITY      (p_par(gi)),
            .STOP_BITS   (p_sb(gi))
        ) u_dut (
            .tx_clk   (clk),
            .reset    (rst),
            .tx_valid (valid[gi]),
            .tx_data  (data[gi][DB-1:0]),
            .tx_ready (ready[gi]),
            .tx_done  (done[gi]),
            .tx_busy  (busy[gi]),
            .tx       (line[gi])
        );
    end

    // Line monitor: decodes frames on falling edges, flags any bit whose
    // level changes inside its CLKS_PER_BIT window (bit 15), drops frames
    // cut by reset, and counts tx_done pulses.
    initial begin
        cyc = 0;
        for (int i = 0; i < NI; i++) begin
            mact[i] = 1'b0;
            mb[i] = 0;
            mc[i] = 0;
            mfr[i] = '0;
            done_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    mact[i] = 1'b0;
                end else begin
                    if (done[i] === 1'b1) done_cnt[i]++;
                    if (!mact[i] && line[i] === 1'b0) begin
                        mact[i] = 1'b1;
                        mb[i] = 0;
                        mc[i] = 0;
                        mfr[i] = '0;
                        st_q[i].push_back(cyc);
                    end
                    if (mact[i]) begin
                        if (mc[i] == 0) mfr[i][mb[i]] = line[i];
                        else if (line[i] !== mfr[i][mb[i]]) mfr[i][15] = 1'b1;
                        mc[i]++;
                        if (mc[i] == p_cpb(i)) begin
                            mc[i] = 0;
                            mb[i]++;
                            if (mb[i] == p_nb(i)) begin
                                got_q[i].push_back(mfr[i]);
                                mact[i] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int i, input logic [8:0] d, output int acc_cyc);
        int t;
        t = 0;
        acc_cyc = -1;
        @(negedge clk);
        while (!ready[i] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!ready[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout inst%0d ready=%b required 1", i, ready[i]);
        end else begin
            valid[i] = 1'b1;
            data[i] = d;
            @(posedge clk);
            acc_cyc = cyc;
            exp_q[i].push_back(d);
            #1 valid[i] = 1'b0;
        end
    endtask

    task automatic wait_frames(input int i, input int n, output bit to);
        int t;
        t = 0;
        while (got_q[i].size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        to = (got_q[i].size() < n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_cmp++; if (line[i] !== 1'b1) begin n_bad++; $display("FAIL reset_tx inst%0d got %b want 1", i, line[i]); end
            n_cmp++; if (ready[i] !== 1'b1) begin n_bad++; $display("FAIL reset_ready inst%0d got %b want 1", i, ready[i]); end
            n_cmp++; if (done[i] !== 1'b0) begin n_bad++; $display("FAIL reset_done inst%0d got %b want 0", i, done[i]); end
            n_cmp++; if (busy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy inst%0d got %b want 0", i, busy[i]); end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        $display("reset: %0d instances checked idle", NI);
    endtask

    task automatic test_default();
        int acc, busy_n, d0, t;
        bit to;
        logic [15:0] g, e;
        busy_n = 0;
        t = 0;
        d0 = done_cnt[0];
        send(0, 9'h0A5, acc);
        // Edge N: word held, line still idle.
        n_cmp++; if (line[0] !== 1'b1 || busy[0] !== 1'b0) begin n_bad++; $display("FAIL latency_n tx=%b busy=%b want tx=1 busy=0", line[0], busy[0]); end
        @(posedge clk);
        #1;
        n_cmp++; if (line[0] !== 1'b0 || busy[0] !== 1'b1) begin n_bad++; $display("FAIL latency_n1 tx=%b busy=%b want tx=0 busy=1", line[0], busy[0]); end
        @(negedge clk);
        while (busy[0] && t < 1000) begin
            busy_n++;
            @(negedge clk);
            t++;
        end
        n_cmp++; if (busy_n != 160) begin n_bad++; $display("FAIL busy_len got %0d cycles want 160", busy_n); end
        repeat (4) @(negedge clk);
        n_cmp++; if (done_cnt[0] - d0 != 1) begin n_bad++; $display("FAIL default_done got %0d pulses want 1", done_cnt[0] - d0); end
        wait_frames(0, 1, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL default_timeout got %0d frames want 1", got_q[0].size()); end
        n_cmp++; if (got_q[0].size() != exp_q[0].size()) begin n_bad++; $display("FAIL default_count got %0d want %0d", got_q[0].size(), exp_q[0].size()); end
        while (got_q[0].size() > 0 && exp_q[0].size() > 0) begin
            g = got_q[0].pop_front();
            e = exp_frame(0, exp_q[0].pop_front());
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL default_frame got %h want %h", g, e); end
            // Line sequence 0,1,0,1,0,0,1,0,1,1 with clean bit timing.
            n_cmp++; if (g !== 16'h034A) begin n_bad++; $display("FAIL default_a5_bits got %h want 034a", g); end
            $display("default: frame %h busy=%0d", g, busy_n);
        end
        got_q[0].delete();
        exp_q[0].delete();
    endtask

    task automatic test_parity();
        int acc;
        bit to;
        logic [15:0] g, e;
        send(1, 9'h055, acc);
        send(1, 9'h007, acc);
        send(2, 9'h055, acc);
        send(2, 9'h00C, acc);
        for (int i = 1; i <= 2; i++) begin
            wait_frames(i, 2, to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL parity_timeout inst%0d got %0d frames want 2", i, got_q[i].size()); end
            if (got_q[i].size() > 0) begin
                g = got_q[i][0];
                n_cmp++; if (g[7:1] !== 7'h55) begin n_bad++; $display("FAIL parity_55_data inst%0d got %h want 55", i, g[7:1]); end
                n_cmp++; if (g[8] !== ((i == 2) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL parity_55_bit inst%0d got %b want %b", i, g[8], (i == 2)); end
            end
            n_cmp++; if (got_q[i].size() != exp_q[i].size()) begin n_bad++; $display("FAIL parity_count inst%0d got %0d want %0d", i, got_q[i].size(), exp_q[i].size()); end
            while (got_q[i].size() > 0 && exp_q[i].size() > 0) begin
                g = got_q[i].pop_front();
                e = exp_frame(i, exp_q[i].pop_front());
                n_cmp++; if (g !== e) begin n_bad++; $display("FAIL parity_frame inst%0d got %h want %h", i, g, e); end
                $display("parity: inst%0d frame %h", i, g);
            end
            got_q[i].delete();
            exp_q[i].delete();
        end
    endtask

    task automatic test_back_to_back();
        int acc, d0, s0, s1;
        bit to;
        logic [15:0] g, e;
        st_q[3].delete();
        d0 = done_cnt[3];
        send(3, 9'h000, acc);
        send(3, 9'h0FF, acc);
        wait_frames(3, 2, to);
        repeat (3) @(negedge clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL b2b_timeout got %0d frames want 2", got_q[3].size()); end
        s0 = (st_q[3].size() > 0) ? st_q[3][0] : 0;
        s1 = (st_q[3].size() > 1) ? st_q[3][1] : 0;
        // 11 bits x 4 cycles: second start 8 cycles after the first stop begins.
        n_cmp++; if (s1 - s0 != 44) begin n_bad++; $display("FAIL b2b_gap got %0d cycles want 44", s1 - s0); end
        n_cmp++; if (done_cnt[3] - d0 != 2) begin n_bad++; $display("FAIL b2b_done got %0d pulses want 2", done_cnt[3] - d0); end
        n_cmp++; if (got_q[3].size() != exp_q[3].size()) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", got_q[3].size(), exp_q[3].size()); end
        while (got_q[3].size() > 0 && exp_q[3].size() > 0) begin
            g = got_q[3].pop_front();
            e = exp_frame(3, exp_q[3].pop_front());
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_frame got %h want %h", g, e); end
            $display("back_to_back: frame %h gap=%0d", g, s1 - s0);
        end
        got_q[3].delete();
        exp_q[3].delete();
    endtask

    task automatic test_hold_full();
        logic [8:0] w [3];
        int acc [3];
        int k, t, d0;
        logic r;
        bit to;
        logic [15:0] g, e;
        w[0] = 9'h03C;
        w[1] = 9'h0A1;
        w[2] = 9'h05E;
        k = 0;
        t = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        d0 = done_cnt[3];
        while (k < 3 && t < 500) begin
            @(negedge clk);
            r = ready[3];
            valid[3] = 1'b1;
            // Junk on the bus whenever the holding register cannot accept.
            data[3] = r ? w[k] : 9'($urandom);
            @(posedge clk);
            if (r) begin
                acc[k] = cyc;
                exp_q[3].push_back(w[k]);
                k++;
            end
            t++;
        end
        #1 valid[3] = 1'b0;
        n_cmp++; if (k != 3) begin n_bad++; $display("FAIL hold_accepts got %0d want 3", k); end
        // 2nd: right after the 1st moves to the shift register; 3rd: right after
        // the 2nd moves over at the end of frame 1 (44 cycles later).
        n_cmp++; if (acc[1] - acc[0] != 2) begin n_bad++; $display("FAIL hold_acc2 got %0d want 2", acc[1] - acc[0]); end
        n_cmp++; if (acc[2] - acc[0] != 46) begin n_bad++; $display("FAIL hold_acc3 got %0d want 46", acc[2] - acc[0]); end
        wait_frames(3, 3, to);
        repeat (3) @(negedge clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL hold_timeout got %0d frames want 3", got_q[3].size()); end
        n_cmp++; if (done_cnt[3] - d0 != 3) begin n_bad++; $display("FAIL hold_done got %0d pulses want 3", done_cnt[3] - d0); end
        n_cmp++; if (got_q[3].size() != exp_q[3].size()) begin n_bad++; $display("FAIL hold_count got %0d want %0d", got_q[3].size(), exp_q[3].size()); end
        while (got_q[3].size() > 0 && exp_q[3].size() > 0) begin
            g = got_q[3].pop_front();
            e = exp_frame(3, exp_q[3].pop_front());
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL hold_frame got %h want %h", g, e); end
            $display("hold_full: frame %h", g);
        end
        got_q[3].delete();
        exp_q[3].delete();
    endtask

    task automatic test_reset_mid();
        int acc, d0;
        bit to;
        logic [15:0] g, e;
        d0 = done_cnt[0];
        send(0, 9'h0C3, acc);   // edge N; frame starts at N+1
        send(0, 9'h099, acc);   // edge N+2, held
        // Data bit 3 of 0xC3 (a 0) spans edges N+65..N+81.
        repeat (68) @(posedge clk);
        #1;
        n_cmp++; if (line[0] !== 1'b0 || ready[0] !== 1'b0) begin n_bad++; $display("FAIL mid_prereset tx=%b ready=%b want tx=0 ready=0", line[0], ready[0]); end
        rst = 1'b1;
        #1;
        n_cmp++; if (line[0] !== 1'b1) begin n_bad++; $display("FAIL mid_reset_tx got %b want 1", line[0]); end
        n_cmp++; if (ready[0] !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready got %b want 1", ready[0]); end
        n_cmp++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags busy=%b done=%b want 0 0", busy[0], done[0]); end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q[0].delete();
        repeat (200) @(negedge clk);
        n_cmp++; if (got_q[0].size() != 0) begin n_bad++; $display("FAIL mid_no_frame got %0d frames want 0", got_q[0].size()); end
        n_cmp++; if (done_cnt[0] != d0) begin n_bad++; $display("FAIL mid_no_done got %0d pulses want 0", done_cnt[0] - d0); end
        got_q[0].delete();
        send(0, 9'h05A, acc);
        wait_frames(0, 1, to);
        repeat (3) @(negedge clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL mid_timeout got %0d frames want 1", got_q[0].size()); end
        n_cmp++; if (done_cnt[0] - d0 != 1) begin n_bad++; $display("FAIL mid_done got %0d pulses want 1", done_cnt[0] - d0); end
        n_cmp++; if (got_q[0].size() != exp_q[0].size()) begin n_bad++; $display("FAIL mid_count got %0d want %0d", got_q[0].size(), exp_q[0].size()); end
        while (got_q[0].size() > 0 && exp_q[0].size() > 0) begin
            g = got_q[0].pop_front();
            e = exp_frame(0, exp_q[0].pop_front());
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL mid_frame got %h want %h", g, e); end
            $display("reset_mid: clean frame %h", g);
        end
        got_q[0].delete();
        exp_q[0].delete();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            valid[i] = 1'b0;
            data[i] = '0;
        end
        test_reset();
        test_default();
        test_parity();
        test_back_to_back();
        test_hold_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t limit=2000000", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
